rat_io_ctrl: RTL and testbench

RAT_IO_CTRL -- requirements
Module: rat_io_ctrl

---
 rtl/rat_io_pkg.sv | 19 +
 rtl/rat_io_sync.sv | 64 ++++++
 rtl/rat_io_ctrl.sv | 135 +++++++++++++
 tb/tb_rat_io_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rat_io_pkg.sv
// Shared constants, FSM state type and address-map helper for the RAT I/O controller.
package rat_io_pkg;

  localparam logic [7:0] MASK_ID = 8'hE0;
  localparam logic [7:0] PEND_ID = 8'hE1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_SERVICE
  } state_e;

  // True when [a_base, a_base+a_num) and [b_base, b_base+b_num) share any ID.
  function automatic logic ranges_overlap(input int a_base, input int a_num,
                                          input int b_base, input int b_num);
    return (a_base < b_base + b_num) && (b_base < a_base + a_num);
  endfunction

endpackage

// File: rtl/rat_io_sync.sv
// Per-bit input conditioning with rising-edge detect. RAT_IO_SYNC_EN selects a
// 2-flop synchronizer ahead of the edge detector; otherwise the input is used directly.
module rat_io_sync #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [W-1:0] rise
);

`ifdef RAT_IO_SYNC_EN
  localparam int ARM_W = 3;

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking
  // assignments here would collapse the two synchronizer stages into one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign dout = s2_q;
`else
  localparam int ARM_W = 1;

  assign dout = din;
`endif

  // Edge detection stays disarmed until the pipeline holds real post-reset samples,
  // so a source already high at release is never mistaken for a rising edge.
  logic [W-1:0]     prev_q, prev_d;
  logic [ARM_W-1:0] arm_q, arm_d;

  always_comb begin
    prev_d = dout;
    arm_d  = (arm_q << 1) | ARM_W'(1);
    rise   = dout & ~prev_q & {W{arm_q[ARM_W-1]}};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

endmodule

// File: rtl/rat_io_ctrl.sv
// RAT MCU I/O controller: output registers, input port mux, maskable edge interrupts.
// Optional build macro RAT_IO_SYNC_EN adds 2-flop synchronizers on IN_DATA and IRQ_SRC.
module rat_io_ctrl
  import rat_io_pkg::*;
#(
  parameter int         DATA_W   = 8,
  parameter int         NUM_OUT  = 4,
  parameter int         NUM_IN   = 4,
  parameter int         NUM_IRQ  = 4,
  parameter logic [7:0] OUT_BASE = 8'h40,
  parameter logic [7:0] IN_BASE  = 8'hF0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [7:0]                PORT_ID,
  input  logic [DATA_W-1:0]         OUT_PORT,
  input  logic                      IO_STRB,
  output logic [DATA_W-1:0]         IN_PORT,
  input  logic [NUM_IN*DATA_W-1:0]  IN_DATA,
  output logic [NUM_OUT*DATA_W-1:0] OUT_DATA,
  input  logic [NUM_IRQ-1:0]        IRQ_SRC,
  output logic                      INTR,
  input  logic                      INT_ACK
);

  localparam int OB = int'(OUT_BASE);
  localparam int IB = int'(IN_BASE);
  localparam int MB = int'(MASK_ID);
  localparam int PB = int'(PEND_ID);

  if (NUM_OUT < 1 || NUM_OUT > 16 || NUM_IN < 1 || NUM_IN > 16 ||
      NUM_IRQ < 1 || NUM_IRQ > DATA_W) begin : g_bad_param
    $error("rat_io_ctrl: NUM_OUT/NUM_IN/NUM_IRQ out of range");
  end

  if (OB + NUM_OUT > 256 || IB + NUM_IN > 256 ||
      ranges_overlap(OB, NUM_OUT, IB, NUM_IN) ||
      ranges_overlap(OB, NUM_OUT, MB, 1) || ranges_overlap(OB, NUM_OUT, PB, 1) ||
      ranges_overlap(IB, NUM_IN, MB, 1)   || ranges_overlap(IB, NUM_IN, PB, 1)) begin : g_bad_map
    $error("rat_io_ctrl: port ID ranges overlap");
  end

  logic [NUM_IN*DATA_W-1:0] in_sync;
  logic [NUM_IN*DATA_W-1:0] unused_in_rise;
  logic [NUM_IRQ-1:0]       irq_lvl;
  logic [NUM_IRQ-1:0]       irq_rise;

  rat_io_sync #(.W(NUM_IN*DATA_W)) u_in_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .din  (IN_DATA),
    .dout (in_sync),
    .rise (unused_in_rise)
  );

  rat_io_sync #(.W(NUM_IRQ)) u_irq_sync (
    .CLK  (CLK),
    .RESET(RESET),
    .din  (IRQ_SRC),
    .dout (irq_lvl),
    .rise (irq_rise)
  );

  logic [NUM_OUT*DATA_W-1:0] out_q, out_d;
  logic [NUM_IRQ-1:0]        mask_q, mask_d;
  logic [NUM_IRQ-1:0]        pend_q, pend_d;
  logic [NUM_IRQ-1:0]        pend_clr;
  state_e                    state_q, state_d;
  logic                      intr_q, intr_d;
  logic                      pend_wr;
  logic                      active;

  // NOTE: every always_comb output gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    out_d    = out_q;
    mask_d   = mask_q;
    pend_clr = '0;
    pend_wr  = IO_STRB && (PORT_ID == PEND_ID);
    if (IO_STRB) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (PORT_ID == OUT_BASE + 8'(i)) out_d[i*DATA_W +: DATA_W] = OUT_PORT;
      end
      if (PORT_ID == MASK_ID) mask_d   = OUT_PORT[NUM_IRQ-1:0];
      if (PORT_ID == PEND_ID) pend_clr = OUT_PORT[NUM_IRQ-1:0];
    end
    // A fresh edge outranks a same-cycle clear.
    pend_d = (pend_q & ~pend_clr) | irq_rise;
  end

  assign active = |(pend_q & mask_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (active) state_d = S_ASSERT;
      S_ASSERT:  if (INT_ACK) state_d = S_SERVICE;
                 else if (!active) state_d = S_IDLE;
      S_SERVICE: if (pend_wr) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    intr_d = (state_d == S_ASSERT);
  end

  // NOTE: the output registers are a few flops, not a RAM, so they take the async
  // reset like any other state and read 0 the instant RESET rises.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_q   <= '0;
      mask_q  <= '0;
      pend_q  <= '0;
      state_q <= S_IDLE;
      intr_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      intr_q  <= intr_d;
    end
  end

  always_comb begin
    IN_PORT = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (PORT_ID == IN_BASE + 8'(i)) IN_PORT = in_sync[i*DATA_W +: DATA_W];
    end
    if (PORT_ID == MASK_ID) IN_PORT = DATA_W'(mask_q);
    if (PORT_ID == PEND_ID) IN_PORT = DATA_W'(pend_q);
  end

  assign OUT_DATA = out_q;
  assign INTR     = intr_q;

endmodule

// File: tb/tb_rat_io_ctrl.sv
// Directed bench for rat_io_ctrl: register/read-mux vector table plus interrupt sequences.
module tb_rat_io_ctrl;

`ifdef RAT_IO_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  PORT_ID = 8'h00;
  logic [7:0]  OUT_PORT = 8'h00;
  logic        IO_STRB = 1'b0;
  logic [7:0]  IN_PORT;
  logic [31:0] IN_DATA = 32'h0;
  logic [31:0] OUT_DATA;
  logic [3:0]  IRQ_SRC = 4'h0;
  logic        INTR;
  logic        INT_ACK = 1'b0;

  int total = 0;
  int bad   = 0;

  rat_io_ctrl dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .PORT_ID (PORT_ID),
    .OUT_PORT(OUT_PORT),
    .IO_STRB (IO_STRB),
    .IN_PORT (IN_PORT),
    .IN_DATA (IN_DATA),
    .OUT_DATA(OUT_DATA),
    .IRQ_SRC (IRQ_SRC),
    .INTR    (INTR),
    .INT_ACK (INT_ACK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        strb;
    logic [7:0]  id;
    logic [7:0]  wdata;
    logic [7:0]  exp_in;
    logic [31:0] exp_out;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] id, input logic [7:0] exp);
    PORT_ID = id;
    #1;
    check(name, 32'(IN_PORT), 32'(exp));
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 8'h42, 8'hA5, 8'h00, 32'h00A5_0000};
    vecs[1]  = '{1'b1, 8'h50, 8'hFF, 8'h00, 32'h00A5_0000};
    vecs[2]  = '{1'b0, 8'h40, 8'h11, 8'h00, 32'h00A5_0000};
    vecs[3]  = '{1'b1, 8'h40, 8'h11, 8'h00, 32'h00A5_0011};
    vecs[4]  = '{1'b1, 8'h43, 8'h5A, 8'h00, 32'h5AA5_0011};
    vecs[5]  = '{1'b0, 8'hF3, 8'h00, 8'h3C, 32'h5AA5_0011};
    vecs[6]  = '{1'b0, 8'hF0, 8'h00, 8'hC3, 32'h5AA5_0011};
    vecs[7]  = '{1'b0, 8'h99, 8'h00, 8'h00, 32'h5AA5_0011};
    vecs[8]  = '{1'b1, 8'h3F, 8'hEE, 8'h00, 32'h5AA5_0011};
    vecs[9]  = '{1'b1, 8'h44, 8'hEE, 8'h00, 32'h5AA5_0011};
    vecs[10] = '{1'b0, 8'hF4, 8'h00, 8'h00, 32'h5AA5_0011};
    vecs[11] = '{1'b0, 8'hEF, 8'h00, 8'h00, 32'h5AA5_0011};
    vecs[12] = '{1'b1, 8'hE0, 8'h0A, 8'h00, 32'h5AA5_0011};
    vecs[13] = '{1'b0, 8'hE0, 8'h00, 8'h0A, 32'h5AA5_0011};
    vecs[14] = '{1'b1, 8'hE0, 8'h00, 8'h0A, 32'h5AA5_0011};
    vecs[15] = '{1'b0, 8'hE1, 8'h00, 8'h00, 32'h5AA5_0011};

    // Reset state
    #1;
    check("rst_intr", 32'(INTR), 32'h0);
    check("rst_out_data", OUT_DATA, 32'h0);
    rd("rst_mask", 8'hE0, 8'h00);
    IN_DATA = 32'h3C77_12C3;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (SYNC_LAT + 2) tick();

    // Register writes and read mux
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      PORT_ID  = vecs[i].id;
      OUT_PORT = vecs[i].wdata;
      IO_STRB  = vecs[i].strb;
      #1;
      check($sformatf("vec%0d_in_port", i), 32'(IN_PORT), 32'(vecs[i].exp_in));
      tick();
      check($sformatf("vec%0d_out_data", i), OUT_DATA, vecs[i].exp_out);
      IO_STRB = 1'b0;
    end

    // Masked source: assert, ack, re-assert from SERVICE via IDLE, then clear
    wr(8'hE0, 8'h02);
    IRQ_SRC = 4'b0010;
    repeat (SYNC_LAT) tick();
    tick();
    rd("a_pending", 8'hE1, 8'h02);
    check("a_intr_not_yet", 32'(INTR), 32'h0);
    tick();
    check("a_intr_rise", 32'(INTR), 32'h1);
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    check("a_intr_after_ack", 32'(INTR), 32'h0);
    tick();
    check("a_service_hold", 32'(INTR), 32'h0);
    wr(8'hE1, 8'h00);
    check("a_to_idle", 32'(INTR), 32'h0);
    tick();
    check("a_reassert", 32'(INTR), 32'h1);
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    wr(8'hE1, 8'h02);
    check("a_cleared_intr", 32'(INTR), 32'h0);
    rd("a_pending_clr", 8'hE1, 8'h00);
    tick();
    check("a_idle_stays", 32'(INTR), 32'h0);
    IRQ_SRC = 4'b0000;
    repeat (SYNC_LAT + 1) tick();

    // Unmasked pending, ack ignored in IDLE, mask enables, mask removal drops INTR
    wr(8'hE0, 8'h00);
    IRQ_SRC[0] = 1'b1;
    repeat (SYNC_LAT) tick();
    tick();
    INT_ACK = 1'b1;
    tick();
    INT_ACK = 1'b0;
    check("b_masked_intr", 32'(INTR), 32'h0);
    rd("b_pending", 8'hE1, 8'h01);
    wr(8'hE0, 8'h01);
    check("b_mask_edge", 32'(INTR), 32'h0);
    tick();
    check("b_intr_rise", 32'(INTR), 32'h1);
    wr(8'hE0, 8'h00);
    check("b_intr_hold", 32'(INTR), 32'h1);
    tick();
    check("b_intr_drop", 32'(INTR), 32'h0);
    wr(8'hE1, 8'h01);
    IRQ_SRC[0] = 1'b0;
    repeat (SYNC_LAT + 1) tick();

    // Same-cycle edge and write-1-to-clear: set wins
    IRQ_SRC[2] = 1'b1;
    repeat (SYNC_LAT) tick();
    tick();
    IRQ_SRC[2] = 1'b0;
    repeat (SYNC_LAT + 2) tick();
    rd("c_pending_pre", 8'hE1, 8'h04);
    IRQ_SRC[2] = 1'b1;
    repeat (SYNC_LAT) tick();
    wr(8'hE1, 8'h04);
    rd("c_set_wins", 8'hE1, 8'h04);
    wr(8'hE1, 8'h04);
    rd("c_plain_clear", 8'hE1, 8'h00);
    IRQ_SRC = 4'b0000;
    repeat (SYNC_LAT + 1) tick();

    // Reset mid-ASSERT; source held high through release
    wr(8'hE0, 8'h01);
    IRQ_SRC[0] = 1'b1;
    repeat (SYNC_LAT) tick();
    tick();
    tick();
    check("d_intr_before", 32'(INTR), 32'h1);
    #2;
    RESET = 1'b1;
    #1;
    check("d_rst_intr", 32'(INTR), 32'h0);
    check("d_rst_out_data", OUT_DATA, 32'h0);
    rd("d_rst_pending", 8'hE1, 8'h00);
    rd("d_rst_mask", 8'hE0, 8'h00);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (SYNC_LAT + 4) tick();
    check("d_no_irq_after_release", 32'(INTR), 32'h0);
    rd("d_no_pending_after_release", 8'hE1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
